// File: rtl/memory_operand_fetch_if.sv
// memory_operand_fetch_if: bundle, execute-side and load-port signals of the operand fetch stage
// slave: view used by memory_operand_fetch; master: view used by the surrounding pipeline / memory.
// Vectors are declared [0:N-1], so bit 0 is the MSB.
interface memory_operand_fetch_if;
  logic        validIn, stallOut, stallIn, validOut;
  logic [0:7]  opcodeIn, opcodeOut;
  logic [0:3]  destRegIn, destRegOut;
  logic [0:63] operand1ValIn, operand2ValIn, operand1ValOut, operand2ValOut;
  logic        isMemoryAccessSrc1In, isMemoryAccessSrc2In, isMemoryAccessDestIn, isMemoryAccessDestOut;
  logic [0:63] memoryAddressSrc1In, memoryAddressSrc2In, memoryAddressDestIn, memoryAddressDestOut;
  logic        memReqValidOut, memReqReadyIn, memRespValidIn, memFaultOut;
  logic [0:63] memReqAddrOut, memRespDataIn;
  modport slave (
    input  validIn, opcodeIn, destRegIn, operand1ValIn, operand2ValIn,
           isMemoryAccessSrc1In, isMemoryAccessSrc2In, isMemoryAccessDestIn,
           memoryAddressSrc1In, memoryAddressSrc2In, memoryAddressDestIn,
           stallIn, memReqReadyIn, memRespValidIn, memRespDataIn,
    output stallOut, validOut, opcodeOut, destRegOut, operand1ValOut, operand2ValOut,
           isMemoryAccessDestOut, memoryAddressDestOut, memReqValidOut, memReqAddrOut, memFaultOut
  );
  modport master (
    output validIn, opcodeIn, destRegIn, operand1ValIn, operand2ValIn,
           isMemoryAccessSrc1In, isMemoryAccessSrc2In, isMemoryAccessDestIn,
           memoryAddressSrc1In, memoryAddressSrc2In, memoryAddressDestIn,
           stallIn, memReqReadyIn, memRespValidIn, memRespDataIn,
    input  stallOut, validOut, opcodeOut, destRegOut, operand1ValOut, operand2ValOut,
           isMemoryAccessDestOut, memoryAddressDestOut, memReqValidOut, memReqAddrOut, memFaultOut
  );
endinterface

// File: rtl/memory_operand_fetch.sv
// memory_operand_fetch: latches a bundle, loads memory source operands over a single-outstanding port, hands it to execute
// Ports: clk, resetN (sync, active-low), bus (memory_operand_fetch_if.slave: upstream bundle, execute handshake, load port, fault).
module memory_operand_fetch #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic resetN,
  memory_operand_fetch_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, HOLD} state_t;
  state_t state, state_nx, first;
  logic [0:CNT_W-1] cnt;
  logic [0:63] addr1, addr2;
  logic src1, src2, accept, wait_st, timeout, done;
  always_comb begin
    accept = bus.validIn && (state == IDLE || (state == HOLD && !bus.stallIn));
    wait_st = state == WAIT1 || state == WAIT2;
    // the last permitted wait cycle: the counter would reach MAX_WAIT at its end
    timeout = cnt == CNT_W'(MAX_WAIT - 1);
    done = bus.memRespValidIn || timeout;
    first = bus.isMemoryAccessSrc1In ? REQ1 : bus.isMemoryAccessSrc2In ? REQ2 : HOLD;
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? first : IDLE;
      REQ1:    state_nx = bus.memReqReadyIn ? WAIT1 : REQ1;
      WAIT1:   state_nx = done ? (src2 ? REQ2 : HOLD) : WAIT1;
      REQ2:    state_nx = bus.memReqReadyIn ? WAIT2 : REQ2;
      WAIT2:   state_nx = done ? HOLD : WAIT2;
      HOLD:    state_nx = bus.stallIn ? HOLD : accept ? first : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign bus.validOut = state == HOLD;
  assign bus.stallOut = state == REQ1 || wait_st || state == REQ2 || (state == HOLD && bus.stallIn);
  assign bus.memReqValidOut = state == REQ1 || state == REQ2;
  assign bus.memReqAddrOut = (state == REQ2 || state == WAIT2) ? addr2 : addr1;
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      cnt <= '0;
      src1 <= 1'b0;
      src2 <= 1'b0;
      addr1 <= '0;
      addr2 <= '0;
      bus.opcodeOut <= '0;
      bus.destRegOut <= '0;
      bus.operand1ValOut <= '0;
      bus.operand2ValOut <= '0;
      bus.isMemoryAccessDestOut <= 1'b0;
      bus.memoryAddressDestOut <= '0;
      bus.memFaultOut <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= wait_st ? cnt + 1'b1 : '0;
      if (accept) begin
        src1 <= bus.isMemoryAccessSrc1In;
        src2 <= bus.isMemoryAccessSrc2In;
        addr1 <= bus.memoryAddressSrc1In;
        addr2 <= bus.memoryAddressSrc2In;
        bus.opcodeOut <= bus.opcodeIn;
        bus.destRegOut <= bus.destRegIn;
        bus.operand1ValOut <= bus.operand1ValIn;
        bus.operand2ValOut <= bus.operand2ValIn;
        bus.isMemoryAccessDestOut <= bus.isMemoryAccessDestIn;
        bus.memoryAddressDestOut <= bus.memoryAddressDestIn;
      end
      if (state == WAIT1 && bus.memRespValidIn) bus.operand1ValOut <= bus.memRespDataIn;
      if (state == WAIT2 && bus.memRespValidIn) bus.operand2ValOut <= bus.memRespDataIn;
      // a timed-out load keeps the register operand and only raises the sticky fault
      if (wait_st && timeout && !bus.memRespValidIn) bus.memFaultOut <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_operand_fetch.sv
// tb_memory_operand_fetch: randomized and directed checks of memory_operand_fetch against a bundle-level model
module tb_memory_operand_fetch;
  localparam int MAXW = 4;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int total = 0;
  int bad = 0;
  logic exp_fault = 1'b0;
  always #5 clk = ~clk;
  memory_operand_fetch_if bus();
  memory_operand_fetch #(.MAX_WAIT(MAXW), .CNT_W(3)) dut (.clk(clk), .resetN(resetN), .bus(bus.slave));
  // rd: cycles the request waits for ready; wd: wait cycles before the response (>= MAXW means none); hs: execute stall cycles
  typedef struct {
    logic [0:7] opc; logic [0:3] dr; logic [0:63] o1, o2, a1, a2, ad, r1, r2;
    logic s1, s2, sd; int rd1, wd1, rd2, wd2, hs;
  } bundle_t;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [0:63] rnd64();
    return {$urandom(), $urandom()};
  endfunction
  function automatic logic [0:272] outs();
    return {bus.stallOut, bus.validOut, bus.memReqValidOut, bus.memFaultOut, bus.opcodeOut, bus.destRegOut,
            bus.operand1ValOut, bus.operand2ValOut, bus.isMemoryAccessDestOut, bus.memoryAddressDestOut, bus.memReqAddrOut};
  endfunction
  function automatic logic [0:204] view();
    return {bus.opcodeOut, bus.destRegOut, bus.operand1ValOut, bus.operand2ValOut, bus.isMemoryAccessDestOut, bus.memoryAddressDestOut};
  endfunction
  function automatic bundle_t mk(input logic [0:63] o1, o2, a1, a2, r1, r2, input logic s1, s2, input int rd1, wd1, rd2, wd2, hs);
    bundle_t b;
    b.opc = 8'($urandom()); b.dr = 4'($urandom()); b.sd = 1'($urandom()); b.ad = rnd64();
    b.o1 = o1; b.o2 = o2; b.a1 = a1; b.a2 = a2; b.r1 = r1; b.r2 = r2; b.s1 = s1; b.s2 = s2;
    b.rd1 = rd1; b.wd1 = wd1; b.rd2 = rd2; b.wd2 = wd2; b.hs = hs;
    return b;
  endfunction
  task automatic drive(input bundle_t b);
    bus.opcodeIn = b.opc; bus.destRegIn = b.dr; bus.operand1ValIn = b.o1; bus.operand2ValIn = b.o2;
    bus.isMemoryAccessSrc1In = b.s1; bus.isMemoryAccessSrc2In = b.s2; bus.isMemoryAccessDestIn = b.sd;
    bus.memoryAddressSrc1In = b.a1; bus.memoryAddressSrc2In = b.a2; bus.memoryAddressDestIn = b.ad;
  endtask
  task automatic scramble();
    bus.opcodeIn = 8'($urandom()); bus.destRegIn = 4'($urandom()); bus.operand1ValIn = rnd64(); bus.operand2ValIn = rnd64();
    bus.isMemoryAccessSrc1In = 1'($urandom()); bus.isMemoryAccessSrc2In = 1'($urandom()); bus.isMemoryAccessDestIn = 1'($urandom());
    bus.memoryAddressSrc1In = rnd64(); bus.memoryAddressSrc2In = rnd64(); bus.memoryAddressDestIn = rnd64();
  endtask
  task automatic reset_dut();
    bus.validIn = 0; bus.stallIn = 0; bus.memReqReadyIn = 0; bus.memRespValidIn = 0; bus.memRespDataIn = '0;
    drive(mk('0, '0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0, 0));
    resetN = 0;
    tick();
    exp_fault = 0;
    total++; if (outs() !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
    resetN = 1;
  endtask
  task automatic load(input logic [0:63] a, input int rd, input int wd, input logic [0:63] r);
    for (int i = 0; i <= rd; i++) begin
      bus.memReqReadyIn = (i == rd);
      bus.memRespValidIn = 1'($urandom());
      bus.memRespDataIn = rnd64();
      #1;
      total++; if ({bus.memReqValidOut, bus.stallOut, bus.validOut} !== 3'b110) begin bad++; $display("FAIL req_ctl got=%b exp=110", {bus.memReqValidOut, bus.stallOut, bus.validOut}); end
      total++; if (bus.memReqAddrOut !== a) begin bad++; $display("FAIL req_addr got=%h exp=%h", bus.memReqAddrOut, a); end
      tick();
    end
    bus.memReqReadyIn = 0;
    for (int i = 0; i < MAXW; i++) begin
      bus.memRespValidIn = (i == wd);
      bus.memRespDataIn = (i == wd) ? r : rnd64();
      #1;
      total++; if ({bus.memReqValidOut, bus.stallOut, bus.validOut, bus.memFaultOut} !== {3'b010, exp_fault}) begin bad++; $display("FAIL wait_ctl got=%b exp=%b", {bus.memReqValidOut, bus.stallOut, bus.validOut, bus.memFaultOut}, {3'b010, exp_fault}); end
      tick();
      if (i == wd) break;
    end
    bus.memRespValidIn = 0;
    if (wd >= MAXW) exp_fault = 1;
  endtask
  task automatic do_bundle(input bundle_t b, input bit accepted);
    logic [0:63] e1, e2;
    e1 = (b.s1 && b.wd1 < MAXW) ? b.r1 : b.o1;
    e2 = (b.s2 && b.wd2 < MAXW) ? b.r2 : b.o2;
    if (!accepted) begin
      drive(b);
      bus.validIn = 1;
      #1;
      total++; if ({bus.stallOut, bus.validOut} !== 2'b00) begin bad++; $display("FAIL accept_ctl got=%b exp=00", {bus.stallOut, bus.validOut}); end
      tick();
    end
    bus.validIn = 0;
    scramble();
    if (b.s1) load(b.a1, b.rd1, b.wd1, b.r1);
    if (b.s2) load(b.a2, b.rd2, b.wd2, b.r2);
    for (int h = 0; h <= b.hs; h++) begin
      bus.stallIn = (h < b.hs);
      bus.memRespValidIn = 1'($urandom());
      bus.memRespDataIn = rnd64();
      #1;
      total++; if (view() !== {b.opc, b.dr, e1, e2, b.sd, b.ad}) begin bad++; $display("FAIL hold_data got=%h exp=%h", view(), {b.opc, b.dr, e1, e2, b.sd, b.ad}); end
      total++; if ({bus.validOut, bus.stallOut, bus.memReqValidOut, bus.memFaultOut} !== {1'b1, h < b.hs, 1'b0, exp_fault}) begin bad++; $display("FAIL hold_ctl got=%b exp=%b", {bus.validOut, bus.stallOut, bus.memReqValidOut, bus.memFaultOut}, {1'b1, h < b.hs, 1'b0, exp_fault}); end
      tick();
    end
    bus.stallIn = 0;
    bus.memRespValidIn = 0;
    #1;
    total++; if ({bus.validOut, bus.stallOut, bus.memReqValidOut} !== 3'b000) begin bad++; $display("FAIL idle_ctl got=%b exp=000", {bus.validOut, bus.stallOut, bus.memReqValidOut}); end
  endtask
  task automatic test_reset();
    reset_dut();
  endtask
  task automatic test_no_mem();
    do_bundle(mk(64'h11, 64'h22, rnd64(), rnd64(), rnd64(), rnd64(), 0, 0, 0, 0, 0, 0, 0), 0);
  endtask
  task automatic test_src1_load();
    do_bundle(mk(rnd64(), 64'h5555, 64'h1000, rnd64(), 64'hDEADBEEF, rnd64(), 1, 0, 3, 2, 0, 0, 1), 0);
  endtask
  task automatic test_both_mem();
    do_bundle(mk(rnd64(), rnd64(), 64'h2000, 64'h3008, 64'hA, 64'hB, 1, 1, 0, 0, 1, 1, 0), 0);
  endtask
  task automatic test_back_to_back();
    bundle_t a, b;
    a = mk(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, 0, 0, 0, 0, 0, 0);
    b = mk(rnd64(), rnd64(), 64'h4440, rnd64(), 64'h77, rnd64(), 1, 0, 1, 0, 0, 0, 0);
    drive(a);
    bus.validIn = 1;
    tick();
    drive(b);
    bus.stallIn = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (view() !== {a.opc, a.dr, a.o1, a.o2, a.sd, a.ad}) begin bad++; $display("FAIL stall_data got=%h exp=%h", view(), {a.opc, a.dr, a.o1, a.o2, a.sd, a.ad}); end
      total++; if ({bus.validOut, bus.stallOut, bus.memReqValidOut} !== 3'b110) begin bad++; $display("FAIL stall_ctl got=%b exp=110", {bus.validOut, bus.stallOut, bus.memReqValidOut}); end
      tick();
    end
    bus.stallIn = 0;
    #1;
    total++; if ({bus.validOut, bus.stallOut} !== 2'b10) begin bad++; $display("FAIL b2b_release got=%b exp=10", {bus.validOut, bus.stallOut}); end
    tick();
    do_bundle(b, 1);
  endtask
  task automatic test_timeout();
    do_bundle(mk(64'h1234, rnd64(), 64'h5000, 64'h5008, rnd64(), 64'hBEEF, 1, 1, 0, MAXW + 2, 2, MAXW - 1, 0), 0);
    do_bundle(mk(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 0, 0, 0, 0, 0, 0, 2), 0);
    reset_dut();
  endtask
  task automatic test_reset_mid_wait2();
    bundle_t b;
    b = mk(rnd64(), rnd64(), 64'h6000, 64'h6008, 64'h99, 64'h98, 1, 1, 0, 0, 0, 0, 0);
    drive(b);
    bus.validIn = 1;
    tick();
    bus.validIn = 0;
    load(b.a1, 0, 0, b.r1);
    bus.memReqReadyIn = 1;
    tick();
    bus.memReqReadyIn = 0;
    #1;
    total++; if ({bus.stallOut, bus.memReqValidOut, bus.memReqAddrOut} !== {2'b10, b.a2}) begin bad++; $display("FAIL wait2_entry got=%h exp=%h", {bus.stallOut, bus.memReqValidOut, bus.memReqAddrOut}, {2'b10, b.a2}); end
    tick();
    reset_dut();
    bus.memRespValidIn = 1;
    bus.memRespDataIn = rnd64();
    tick();
    bus.memRespValidIn = 0;
    #1;
    total++; if (outs() !== '0) begin bad++; $display("FAIL stale_resp got=%h exp=0", outs()); end
    do_bundle(mk(rnd64(), rnd64(), 64'h7000, rnd64(), 64'h42, rnd64(), 1, 0, 1, 1, 0, 0, 1), 0);
  endtask
  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 30; n++)
      do_bundle(mk(rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom()), 1'($urandom()),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3))), 0);
  endtask
  initial begin
    test_reset();
    test_no_mem();
    test_src1_load();
    test_both_mem();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait2();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
